// File: rtl/div_pkg.sv
// +----------------------------------------------------------------------+
// | div_pkg : shared types and constants for the sequential divider       |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  localparam int WD_DEF       = 8;
  localparam int APX_BITS_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; one spare bit above the index range.
  function automatic int cnt_width(input int wd);
    return $clog2(wd) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_restore_step.sv
// +----------------------------------------------------------------------+
// | div_restore_step : one combinational restoring-division iteration     |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module div_restore_step #(
  parameter int WD = 8
) (
  input  logic [WD-1:0] p,
  input  logic          d_bit,
  input  logic [WD-1:0] b,
  output logic [WD-1:0] p_next,
  output logic          q_bit
);

  logic [WD:0]   t;
  logic [WD-1:0] diff;

  // The difference is always < b when taken, so WD bits of it suffice.
  always_comb begin
    t      = {p, d_bit};
    q_bit  = (t >= {1'b0, b});
    diff   = t[WD-1:0] - b;
    p_next = q_bit ? diff : t[WD-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/div_seq_restoring.sv
// +----------------------------------------------------------------------+
// | div_seq_restoring : 2*WD / WD sequential restoring divider with       |
// | valid/ready handshakes. Define DIV_APPROX_EN to truncate the last     |
// | APX_BITS iterations and substitute a midpoint quotient tail.          |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module div_seq_restoring
  import div_pkg::*;
#(
  parameter int WD       = WD_DEF,
  parameter int APX_BITS = APX_BITS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*WD-1:0] A,
  input  logic [WD-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] Q,
  output logic [WD-1:0] Rm,
  output logic          div_by_zero,
  output logic          overflow
);

`ifdef DIV_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  localparam int             CW       = cnt_width(WD);
  localparam int             N_ITER   = APPROX_EN ? (WD - APX_BITS) : WD;
  localparam logic [CW-1:0]  LAST_CNT = CW'(N_ITER - 1);

  state_t        state_q, state_d;
  logic [WD-1:0] a_lo_q, a_lo_d;
  logic [WD-1:0] b_q, b_d;
  logic [WD-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WD-1:0] q_q, q_d;
  logic [WD-1:0] rm_q, rm_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [WD-1:0] p_next;
  logic          q_bit;
  logic [WD-1:0] a_lo_next;
  logic [WD-1:0] quo_final;
  logic [WD-1:0] rm_final;

  div_restore_step #(.WD(WD)) u_step (
    .p      (p_q),
    .d_bit  (a_lo_q[WD-1]),
    .b      (b_q),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  // Dividend bits leave from the top while quotient bits enter at the bottom.
  assign a_lo_next = {a_lo_q[WD-2:0], q_bit};

  generate
    if (APPROX_EN) begin : g_approx
      localparam logic [APX_BITS-1:0] MID = APX_BITS'(1) << (APX_BITS - 1);
      assign quo_final = {a_lo_next[N_ITER-1:0], MID};
      assign rm_final  = '0;
    end else begin : g_exact
      assign quo_final = a_lo_next;
      assign rm_final  = p_next;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_lo_d  = a_lo_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rm_d    = rm_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d   = '0;
          rm_d  = '0;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (B == '0) begin
            q_d     = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (A[2*WD-1:WD] >= B) begin
            q_d     = '1;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            a_lo_d  = A[WD-1:0];
            b_d     = B;
            p_d     = A[2*WD-1:WD];
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d    = p_next;
        a_lo_d = a_lo_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          q_d     = quo_final;
          rm_d    = rm_final;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_lo_q  <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rm_q    <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_lo_q  <= a_lo_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rm_q    <= rm_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign Q           = q_q;
  assign Rm          = rm_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_restoring.sv
// +----------------------------------------------------------------------+
// | tb_div_seq_restoring : randomized self-checking bench for the divider |
// | Rev 1.0 : initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_div_seq_restoring;

  localparam int WD  = 8;
  localparam int APX = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*WD-1:0] A;
  logic [WD-1:0] B;
  logic          out_valid;
  logic          out_ready;
  logic [WD-1:0] Q;
  logic [WD-1:0] Rm;
  logic          div_by_zero;
  logic          overflow;

  int total;
  int bad;

  div_seq_restoring #(.WD(WD), .APX_BITS(APX)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Q           (Q),
    .Rm          (Rm),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the exception and truncation rules.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dbz, output logic ovf, output int lat);
    int unsigned ai, bi;
    ai = a;
    bi = b;
    dbz = 1'b0;
    ovf = 1'b0;
    if (bi == 0) begin
      q = 8'hFF; r = 8'h00; dbz = 1'b1; lat = 0;
    end else if (ai / bi > 255) begin
      q = 8'hFF; r = 8'h00; ovf = 1'b1; lat = 0;
    end else begin
`ifdef DIV_APPROX_EN
      q   = 8'((((ai >> APX) / bi) << APX) | (1 << (APX - 1)));
      r   = 8'h00;
      lat = WD - APX;
`else
      q   = 8'(ai / bi);
      r   = 8'(ai % bi);
      lat = WD;
`endif
    end
  endtask

  task automatic run_div(input logic [15:0] a, input logic [7:0] b, input int hold);
    logic [7:0] eq, er;
    logic       edz, eov;
    int         elat;
    int         lat;
    ref_div(a, b, eq, er, edz, eov, elat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", in_ready, 0);
      in_valid = 1'($urandom % 2);
      A = 16'($urandom);
      B = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, elat);
    for (int i = 0; i <= hold; i++) begin
      chk("out_valid", out_valid, 1);
      chk("in_ready_done", in_ready, 0);
      chk("Q", Q, eq);
      chk("Rm", Rm, er);
      chk("div_by_zero", div_by_zero, edz);
      chk("overflow", overflow, eov);
      if (i < hold) begin
        in_valid = 1'($urandom % 2);
        A = 16'($urandom);
        B = 8'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("Q_held", Q, eq);
    chk("flags_held", {div_by_zero, overflow}, {edz, eov});
  endtask

  initial begin
    logic [7:0]  rb;
    logic [15:0] ra;
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    chk("rst_Q", Q, 0);
    chk("rst_Rm", Rm, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    run_div(16'd1000, 8'd7, 0);
    run_div(16'h1234, 8'h20, 1);
    run_div(16'h0055, 8'h00, 0);
    run_div(16'h8000, 8'h40, 5);
    run_div(16'hFEFF, 8'hFF, 2);
    run_div(16'h00FF, 8'h01, 0);
    run_div(16'h0100, 8'h01, 0);
    run_div(16'hFFFF, 8'h00, 0);

    // Reset in the middle of a running division.
    @(negedge clk);
    A = 16'd1000; B = 8'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_in_ready", in_ready, 1);
    chk("midrun_rst_Q", Q, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
    end
    run_div(16'd1000, 8'd7, 0);

    for (int n = 0; n < 150; n++) begin
      rb = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      if ($urandom % 3 == 0) rb = 8'($urandom % 16);
      ra = 16'($urandom);
      if (rb != 0 && ($urandom % 4 != 0))
        ra[15:8] = 8'($urandom % rb);
      run_div(ra, rb, int'($urandom % 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
